// File: rtl/sys_defs_pkg.sv
// rtl/sys_defs_pkg.sv - shared bus definitions for the data-memory interface
//
// Provides the BUS_COMMAND encoding, the data-cache block width macro
// `DCACHE_BLOCK_SIZE (64 unless defined earlier) and the transaction tag
// width, plus the tag sequencing helper shared by responder and bench.
`ifndef DCACHE_BLOCK_SIZE
`define DCACHE_BLOCK_SIZE 64
`endif

package sys_defs_pkg;

   localparam int DCACHE_BLOCK_BITS = `DCACHE_BLOCK_SIZE;
   localparam int TAG_W             = 4;

   // Encoding 2'b11 is illegal and is treated as BUS_NONE by the responder.
   typedef enum logic [1:0] {
      BUS_NONE  = 2'b00,
      BUS_LOAD  = 2'b01,
      BUS_STORE = 2'b10
   } BUS_COMMAND;

   // Tags run 1..15 and wrap to 1; 0 means "no tag" on both response buses.
   function automatic logic [TAG_W-1:0] tag_advance(input logic [TAG_W-1:0] t);
      return (t == 4'd15) ? 4'd1 : t + 4'd1;
   endfunction

endpackage

// File: rtl/dmem_lat_pipe.sv
// rtl/dmem_lat_pipe.sv - fixed-latency shift register of {valid,tag,data}
//
// Ports:
//   clock     in   rising-edge clock
//   reset     in   asynchronous active-low reset, clears every stage
//   in_valid  in   entry presented at stage 0 this cycle
//   in_tag    in   tag of the entry (0 when not valid)
//   in_data   in   data of the entry (0 when not valid / store)
//   out_valid out  entry leaving the last stage
//   out_tag   out  its tag
//   out_data  out  its data
// An entry loaded at edge T is presented on the outputs during the cycle
// that follows edge T+LATENCY-1, i.e. LATENCY cycles after acceptance.
`ifndef DCACHE_BLOCK_SIZE
`define DCACHE_BLOCK_SIZE 64
`endif

module dmem_lat_pipe
   import sys_defs_pkg::*;
#(
   parameter int LATENCY = 4,
   parameter int DW      = `DCACHE_BLOCK_SIZE,
   parameter int TW      = TAG_W
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          in_valid,
   input  logic [TW-1:0] in_tag,
   input  logic [DW-1:0] in_data,
   output logic          out_valid,
   output logic [TW-1:0] out_tag,
   output logic [DW-1:0] out_data
);

   logic [LATENCY-1:0] stage_valid;
   logic [TW-1:0]      stage_tag  [LATENCY];
   logic [DW-1:0]      stage_data [LATENCY];

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         stage_valid <= '0;
         for (int i = 0; i < LATENCY; i++) begin
            stage_tag[i]  <= '0;
            stage_data[i] <= '0;
         end
      end else begin
         stage_valid[0] <= in_valid;
         stage_tag[0]   <= in_tag;
         stage_data[0]  <= in_data;
         for (int i = 1; i < LATENCY; i++) begin
            stage_valid[i] <= stage_valid[i-1];
            stage_tag[i]   <= stage_tag[i-1];
            stage_data[i]  <= stage_data[i-1];
         end
      end
   end

   assign out_valid = stage_valid[LATENCY-1];
   assign out_tag   = stage_tag[LATENCY-1];
   assign out_data  = stage_data[LATENCY-1];

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - tagged fixed-latency data-memory responder
//
// Accepts one dcache request per cycle, grants it a tag combinationally and
// completes it MEM_LATENCY cycles later with that tag (and load data).
// Optional feature macro: DMEM_BUSY_INJECT_EN (LFSR-driven request rejection).
//
// Ports:
//   clock              in   rising-edge clock
//   reset              in   asynchronous active-low reset
//   proc2Dmem_command  in   BUS_NONE / BUS_LOAD / BUS_STORE
//   proc2Dmem_addr     in   byte address, word index = addr[IDX_BITS+2:3]
//   proc2Dmem_data     in   store data
//   Dmem2proc_response out  tag granted this cycle, 0 = retry
//   Dmem2proc_tag      out  tag completing this cycle, 0 = none
//   Dmem2proc_data     out  load data for the completing tag, else 0
`ifndef DCACHE_BLOCK_SIZE
`define DCACHE_BLOCK_SIZE 64
`endif

module dmem_responder
   import sys_defs_pkg::*;
#(
   parameter int MEM_LATENCY = 4,
   parameter int MEM_DEPTH   = 1024,
   parameter int IDX_BITS    = $clog2(MEM_DEPTH)
) (
   input  logic                          clock,
   input  logic                          reset,
   input  BUS_COMMAND                    proc2Dmem_command,
   input  logic [63:0]                   proc2Dmem_addr,
   input  logic [`DCACHE_BLOCK_SIZE-1:0] proc2Dmem_data,
   output logic [TAG_W-1:0]              Dmem2proc_response,
   output logic [TAG_W-1:0]              Dmem2proc_tag,
   output logic [`DCACHE_BLOCK_SIZE-1:0] Dmem2proc_data
);

   localparam int DW = `DCACHE_BLOCK_SIZE;

   logic [DW-1:0]       mem [MEM_DEPTH];
   logic [IDX_BITS-1:0] word_idx;
   logic [DW-1:0]       rd_word;
   logic [TAG_W-1:0]    next_tag;
   logic                is_load;
   logic                is_store;
   logic                busy;
   logic                accept;
   logic                pipe_valid;
   logic [TAG_W-1:0]    pipe_tag;
   logic [DW-1:0]       pipe_data;
   logic                addr_unused;

   // High and byte-offset address bits alias onto the same word.
   assign word_idx    = proc2Dmem_addr[IDX_BITS+2:3];
   assign addr_unused = ^{proc2Dmem_addr[63:IDX_BITS+3], proc2Dmem_addr[2:0]};

   assign is_load  = (proc2Dmem_command == BUS_LOAD);
   assign is_store = (proc2Dmem_command == BUS_STORE);

`ifdef DMEM_BUSY_INJECT_EN
   // Right-shifting Galois LFSR, taps 16,14,13,11 -> feedback mask 16'hB400.
   logic [15:0] lfsr;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         lfsr <= 16'hACE1;
      end else begin
         lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
      end
   end

   assign busy = (lfsr[1:0] == 2'b00);
`else
   assign busy = 1'b0;
`endif

   // Gated by reset so no grant is ever visible while the pipe is held clear.
   assign accept             = reset && (is_load || is_store) && !busy;
   assign Dmem2proc_response = accept ? next_tag : '0;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         next_tag <= 4'd1;
      end else if (accept) begin
         next_tag <= tag_advance(next_tag);
      end
   end

   // Backing RAM deliberately has no reset. The read is asynchronous so a
   // load right after a store to the same word already sees the new value.
   always_ff @(posedge clock) begin
      if (accept && is_store) begin
         mem[word_idx] <= proc2Dmem_data;
      end
   end

   assign rd_word = mem[word_idx];

   dmem_lat_pipe #(
      .LATENCY (MEM_LATENCY),
      .DW      (DW),
      .TW      (TAG_W)
   ) u_pipe (
      .clock     (clock),
      .reset     (reset),
      .in_valid  (accept),
      .in_tag    (accept ? next_tag : '0),
      .in_data   ((accept && is_load) ? rd_word : '0),
      .out_valid (pipe_valid),
      .out_tag   (pipe_tag),
      .out_data  (pipe_data)
   );

   assign Dmem2proc_tag  = pipe_valid ? pipe_tag  : '0;
   assign Dmem2proc_data = pipe_valid ? pipe_data : '0;

endmodule
